// File: rtl/udlx_pkg.sv
// uDLX shared definitions: register-zero address, ALU opcodes and the
// EX control-bit bundle carried from ID into EX.
package udlx_pkg;

   localparam int REG_ZERO = 0;

   localparam logic [3:0] ALU_ADD  = 4'h0;
   localparam logic [3:0] ALU_SUB  = 4'h1;
   localparam logic [3:0] ALU_AND  = 4'h2;
   localparam logic [3:0] ALU_OR   = 4'h3;
   localparam logic [3:0] ALU_XOR  = 4'h4;
   localparam logic [3:0] ALU_SLL  = 4'h5;
   localparam logic [3:0] ALU_SRL  = 4'h6;
   localparam logic [3:0] ALU_SRA  = 4'h7;
   localparam logic [3:0] ALU_SLT  = 4'h8;
   localparam logic [3:0] ALU_SLTU = 4'h9;
   localparam logic [3:0] ALU_LUI  = 4'hA;

   typedef struct packed {
      logic reg_wr;
      logic mem_rd;
      logic mem_wr;
   } ctrl_t;

   localparam ctrl_t CTRL_BUBBLE = '{reg_wr: 1'b0, mem_rd: 1'b0, mem_wr: 1'b0};

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard check between the load sitting in EX and the
// instruction currently decoded in ID.
module load_use_detect
   import udlx_pkg::*;
#(
   parameter int REG_ADDR_WIDTH = 5
) (
   input  logic                      ex_valid,
   input  ctrl_t                     ex_ctrl,
   input  logic [REG_ADDR_WIDTH-1:0] ex_dst,
   input  logic                      id_valid,
   input  logic [REG_ADDR_WIDTH-1:0] id_addr_a,
   input  logic [REG_ADDR_WIDTH-1:0] id_addr_b,
   input  logic                      id_use_b,
   output logic                      load_use
);

   logic ex_is_load;
   logic hit_a;
   logic hit_b;

   assign ex_is_load = ex_valid & ex_ctrl.mem_rd & ex_ctrl.reg_wr
                     & (ex_dst != REG_ADDR_WIDTH'(REG_ZERO));
   assign hit_a = (ex_dst == id_addr_a);
   assign hit_b = id_use_b & (ex_dst == id_addr_b);

   assign load_use = ex_is_load & id_valid & (hit_a | hit_b);

endmodule

// File: rtl/id_ex_pipe.sv
// uDLX ID/EX pipeline register with load-use bubble and WB bypass.
// Optional perf counters: define ID_EX_PERF_CNT_EN.
module id_ex_pipe
   import udlx_pkg::*;
#(
   parameter int DATA_WIDTH     = 32,
   parameter int REG_ADDR_WIDTH = 5,
   parameter int ALU_OP_WIDTH   = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      id_valid_in,
   input  logic [DATA_WIDTH-1:0]     id_data_a_in,
   input  logic [DATA_WIDTH-1:0]     id_data_b_in,
   input  logic [REG_ADDR_WIDTH-1:0] id_addr_a_in,
   input  logic [REG_ADDR_WIDTH-1:0] id_addr_b_in,
   input  logic                      id_use_b_in,
   input  logic [DATA_WIDTH-1:0]     id_imm_in,
   input  logic [ALU_OP_WIDTH-1:0]   id_alu_op_in,
   input  logic [REG_ADDR_WIDTH-1:0] id_reg_dst_addr_in,
   input  logic                      id_reg_wr_ena_in,
   input  logic                      id_mem_rd_ena_in,
   input  logic                      id_mem_wr_ena_in,
   input  logic [DATA_WIDTH-1:0]     wb_reg_data_in,
   input  logic [REG_ADDR_WIDTH-1:0] wb_reg_addr_in,
   input  logic                      wb_reg_wr_ena_in,
   input  logic                      ex_stall_in,
   input  logic                      flush_in,
   output logic                      ex_valid_out,
   output logic [DATA_WIDTH-1:0]     ex_data_a_out,
   output logic [DATA_WIDTH-1:0]     ex_data_b_out,
   output logic [REG_ADDR_WIDTH-1:0] ex_addr_a_out,
   output logic [REG_ADDR_WIDTH-1:0] ex_addr_b_out,
   output logic [DATA_WIDTH-1:0]     ex_imm_out,
   output logic [ALU_OP_WIDTH-1:0]   ex_alu_op_out,
   output logic [REG_ADDR_WIDTH-1:0] ex_reg_dst_addr_out,
   output logic                      ex_reg_wr_ena_out,
   output logic                      ex_mem_rd_ena_out,
   output logic                      ex_mem_wr_ena_out,
`ifdef ID_EX_PERF_CNT_EN
   output logic [31:0]               bubble_cnt_out,
   output logic [31:0]               stall_cnt_out,
`endif
   output logic                      id_stall_out
);

   localparam logic [REG_ADDR_WIDTH-1:0] R0 = REG_ADDR_WIDTH'(REG_ZERO);

   logic                      ex_valid_q;
   logic [DATA_WIDTH-1:0]     ex_a_q;
   logic [DATA_WIDTH-1:0]     ex_b_q;
   logic [REG_ADDR_WIDTH-1:0] ex_aa_q;
   logic [REG_ADDR_WIDTH-1:0] ex_ab_q;
   logic [DATA_WIDTH-1:0]     ex_imm_q;
   logic [ALU_OP_WIDTH-1:0]   ex_op_q;
   logic [REG_ADDR_WIDTH-1:0] ex_dst_q;
   ctrl_t                     ex_ctrl_q;

   ctrl_t                     id_ctrl;
   logic [DATA_WIDTH-1:0]     byp_a;
   logic [DATA_WIDTH-1:0]     byp_b;
   logic                      load_use;
   logic                      sel_hold;
   logic                      sel_bub;

   assign id_ctrl = '{reg_wr: id_reg_wr_ena_in,
                      mem_rd: id_mem_rd_ena_in,
                      mem_wr: id_mem_wr_ena_in};

   load_use_detect #(
      .REG_ADDR_WIDTH(REG_ADDR_WIDTH)
   ) u_lud (
      .ex_valid  (ex_valid_q),
      .ex_ctrl   (ex_ctrl_q),
      .ex_dst    (ex_dst_q),
      .id_valid  (id_valid_in),
      .id_addr_a (id_addr_a_in),
      .id_addr_b (id_addr_b_in),
      .id_use_b  (id_use_b_in),
      .load_use  (load_use)
   );

   // r0 always reads zero; otherwise a same-cycle WB write wins over the RF
   always_comb begin
      byp_a = id_data_a_in;
      if (id_addr_a_in == R0)
         byp_a = '0;
      else if (wb_reg_wr_ena_in && (wb_reg_addr_in == id_addr_a_in))
         byp_a = wb_reg_data_in;
   end

   always_comb begin
      byp_b = id_data_b_in;
      if (id_addr_b_in == R0)
         byp_b = '0;
      else if (wb_reg_wr_ena_in && (wb_reg_addr_in == id_addr_b_in))
         byp_b = wb_reg_data_in;
   end

   assign sel_hold     = ex_stall_in;
   assign sel_bub      = ~ex_stall_in & (flush_in | load_use);
   assign id_stall_out = ex_stall_in | (load_use & ~flush_in);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_valid_q <= 1'b0;
         ex_a_q     <= '0;
         ex_b_q     <= '0;
         ex_aa_q    <= '0;
         ex_ab_q    <= '0;
         ex_imm_q   <= '0;
         ex_op_q    <= '0;
         ex_dst_q   <= '0;
         ex_ctrl_q  <= CTRL_BUBBLE;
      end else begin
         unique case (1'b1)
            sel_hold: begin
            end
            sel_bub: begin
               ex_valid_q <= 1'b0;
               ex_a_q     <= '0;
               ex_b_q     <= '0;
               ex_aa_q    <= '0;
               ex_ab_q    <= '0;
               ex_imm_q   <= '0;
               ex_op_q    <= '0;
               ex_dst_q   <= '0;
               ex_ctrl_q  <= CTRL_BUBBLE;
            end
            default: begin
               ex_valid_q <= id_valid_in;
               ex_a_q     <= byp_a;
               ex_b_q     <= byp_b;
               ex_aa_q    <= id_addr_a_in;
               ex_ab_q    <= id_addr_b_in;
               ex_imm_q   <= id_imm_in;
               ex_op_q    <= id_alu_op_in;
               ex_dst_q   <= id_reg_dst_addr_in;
               ex_ctrl_q  <= id_valid_in ? id_ctrl : CTRL_BUBBLE;
            end
         endcase
      end
   end

   assign ex_valid_out        = ex_valid_q;
   assign ex_data_a_out       = ex_a_q;
   assign ex_data_b_out       = ex_b_q;
   assign ex_addr_a_out       = ex_aa_q;
   assign ex_addr_b_out       = ex_ab_q;
   assign ex_imm_out          = ex_imm_q;
   assign ex_alu_op_out       = ex_op_q;
   assign ex_reg_dst_addr_out = ex_dst_q;
   assign ex_reg_wr_ena_out   = ex_ctrl_q.reg_wr;
   assign ex_mem_rd_ena_out   = ex_ctrl_q.mem_rd;
   assign ex_mem_wr_ena_out   = ex_ctrl_q.mem_wr;

`ifdef ID_EX_PERF_CNT_EN
   logic [31:0] bub_q;
   logic [31:0] stl_q;

   // a flushed load-use counts as a flush, not as a load-use bubble
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bub_q <= '0;
         stl_q <= '0;
      end else begin
         if (sel_bub && !flush_in && load_use && (bub_q != '1))
            bub_q <= bub_q + 32'd1;
         if (ex_stall_in && (stl_q != '1))
            stl_q <= stl_q + 32'd1;
      end
   end

   assign bubble_cnt_out = bub_q;
   assign stall_cnt_out  = stl_q;
`endif

endmodule
